periph_mem_ctrl: RTL and testbench

PERIPH_MEM_CTRL -- requirements
Module: periph_mem_ctrl

---
 rtl/periph_mem_ctrl.sv | 159 +++++++++++++++
 tb/tb_periph_mem_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/periph_mem_ctrl.sv
// CPU-side memory controller: routes single-word accesses either to an external
// asynchronous SRAM (with programmable wait states) or to a small peripheral window.
module periph_mem_ctrl #(
    parameter int unsigned          DATAWIDTH   = 16,
    parameter int unsigned          ADDRWIDTH   = 16,
    parameter logic [ADDRWIDTH-5:0] PERIPH_TAG  = 12'hFDF,
    parameter int unsigned          WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic [DATAWIDTH-1:0] wdata,
    output logic [DATAWIDTH-1:0] rdata,
    output logic                 ack,
    output logic                 err,
    output logic                 busy,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic [ADDRWIDTH-1:0] sram_addr,
    output logic [DATAWIDTH-1:0] sram_dout,
    input  logic [DATAWIDTH-1:0] sram_din,
    output logic                 ctrlr_re,
    output logic [1:0]           ctrlr_addr,
    input  logic [DATAWIDTH-1:0] ctrlr_din,
    output logic                 audio_we,
    output logic [1:0]           audio_addr,
    output logic [DATAWIDTH-1:0] audio_dout,
    output logic                 timer_re,
    input  logic [DATAWIDTH-1:0] timer_din
);

    typedef enum logic [1:0] {IDLE, SRAM_ACC, PERIPH, RESP} state_t;

    localparam logic [2:0] LAST_CNT = 3'(WAIT_STATES);

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [ADDRWIDTH-1:0]   addr_q, addr_d;
    logic                   we_q, we_d;
    logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
    logic [DATAWIDTH-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic                   sram_last;
    logic                   p_ctrl, p_audio, p_timer, p_err;

    assign sram_last = (cnt_q == LAST_CNT);

    // Peripheral offset decode; anything not a legal load/store pair is an error.
    assign p_ctrl  = (addr_q[3:2] == 2'd0) && !we_q;
    assign p_audio = (addr_q[3:2] == 2'd1) &&  we_q;
    assign p_timer = (addr_q[3:0] == 4'd8) && !we_q;
    assign p_err   = !(p_ctrl || p_audio || p_timer);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                    cnt_d   = '0;
                    state_d = (addr[ADDRWIDTH-1:4] == PERIPH_TAG) ? PERIPH : SRAM_ACC;
                end
            end
            SRAM_ACC: begin
                if (sram_last) begin
                    cnt_d   = '0;
                    rdata_d = we_q ? '0 : sram_din;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            PERIPH: begin
                err_d   = p_err;
                state_d = RESP;
                if (p_ctrl)       rdata_d = ctrlr_din;
                else if (p_timer) rdata_d = timer_din;
                else              rdata_d = '0;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        ack        = (state_q == RESP);
        err        = (state_q == RESP) && err_q;
        rdata      = rdata_q;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_addr  = '0;
        sram_dout  = '0;
        ctrlr_re   = 1'b0;
        ctrlr_addr = '0;
        audio_we   = 1'b0;
        audio_addr = '0;
        audio_dout = '0;
        timer_re   = 1'b0;
        case (state_q)
            SRAM_ACC: begin
                sram_ce_n = 1'b0;
                sram_addr = addr_q;
                sram_dout = wdata_q;
                sram_oe_n = we_q;
                // Last cycle of a store is a hold cycle, unless it is the only cycle.
                sram_we_n = !(we_q && (!sram_last || (LAST_CNT == 3'd0)));
            end
            PERIPH: begin
                if (p_ctrl) begin
                    ctrlr_re   = 1'b1;
                    ctrlr_addr = addr_q[1:0];
                end
                if (p_audio) begin
                    audio_we   = 1'b1;
                    audio_addr = addr_q[1:0];
                    audio_dout = wdata_q;
                end
                if (p_timer) timer_re = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_periph_mem_ctrl.sv
// Directed bench for periph_mem_ctrl at default parameters (16-bit, WAIT_STATES=2).
module tb_periph_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset, req, we;
    logic [15:0] addr, wdata, rdata, sram_addr, sram_dout, sram_din;
    logic [15:0] ctrlr_din, audio_dout, timer_din;
    logic        ack, err, busy, sram_ce_n, sram_oe_n, sram_we_n;
    logic        ctrlr_re, audio_we, timer_re;
    logic [1:0]  ctrlr_addr, audio_addr;
    logic [2:0]  sram_ctl, strb;

    int checks = 0;
    int errors = 0;

    assign sram_ctl = {sram_ce_n, sram_oe_n, sram_we_n};
    assign strb     = {ctrlr_re, audio_we, timer_re};

    always #5 clk = ~clk;

    periph_mem_ctrl #(
        .DATAWIDTH  (16),
        .ADDRWIDTH  (16),
        .PERIPH_TAG (12'hFDF),
        .WAIT_STATES(2)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .busy(busy),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
        .ctrlr_re(ctrlr_re), .ctrlr_addr(ctrlr_addr), .ctrlr_din(ctrlr_din),
        .audio_we(audio_we), .audio_addr(audio_addr), .audio_dout(audio_dout),
        .timer_re(timer_re), .timer_din(timer_din)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        sram_din = '0; ctrlr_din = '0; timer_din = '0;
        #1;
        checks++; if (sram_ctl !== 3'b111) begin errors++; $display("FAIL reset_sram_ctl: got %b expected 111", sram_ctl); end
        checks++; if ({busy, ack, err, strb} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b expected 000000", {busy, ack, err, strb}); end
        step();
        checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
        checks++; if ({sram_addr, sram_dout, audio_dout, ctrlr_addr, audio_addr} !== 52'h0) begin
            errors++; $display("FAIL reset_buses: got %h expected 0", {sram_addr, sram_dout, audio_dout, ctrlr_addr, audio_addr}); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_sram_load();
        req = 1'b1; we = 1'b0; addr = 16'h1234; sram_din = 16'hBEEF;
        step();
        req = 1'b0; addr = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            checks++; if (sram_ctl !== 3'b001) begin errors++; $display("FAIL load_ctl[%0d]: got %b expected 001", i, sram_ctl); end
            checks++; if (sram_addr !== 16'h1234) begin errors++; $display("FAIL load_addr[%0d]: got %h expected 1234", i, sram_addr); end
            checks++; if ({busy, ack} !== 2'b10) begin errors++; $display("FAIL load_busy_ack[%0d]: got %b expected 10", i, {busy, ack}); end
            step();
        end
        checks++; if ({ack, err} !== 2'b10) begin errors++; $display("FAIL load_ack: got %b expected 10", {ack, err}); end
        checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL load_rdata: got %h expected beef", rdata); end
        checks++; if (sram_ctl !== 3'b111) begin errors++; $display("FAIL load_resp_ctl: got %b expected 111", sram_ctl); end
        step();
        checks++; if ({busy, ack} !== 2'b00) begin errors++; $display("FAIL load_idle: got %b expected 00", {busy, ack}); end
        checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL load_rdata_hold: got %h expected beef", rdata); end
    endtask

    task automatic test_sram_store();
        req = 1'b1; we = 1'b1; addr = 16'h0040; wdata = 16'h00AA;
        step();
        req = 1'b0; wdata = 16'h5A5A;
        for (int i = 0; i < 3; i++) begin
            checks++; if (sram_ctl !== ((i < 2) ? 3'b010 : 3'b011)) begin
                errors++; $display("FAIL store_ctl[%0d]: got %b expected %b", i, sram_ctl, (i < 2) ? 3'b010 : 3'b011); end
            checks++; if ({sram_addr, sram_dout} !== {16'h0040, 16'h00AA}) begin
                errors++; $display("FAIL store_bus[%0d]: got %h/%h expected 0040/00aa", i, sram_addr, sram_dout); end
            step();
        end
        checks++; if ({ack, err} !== 2'b10) begin errors++; $display("FAIL store_ack: got %b expected 10", {ack, err}); end
        checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL store_rdata: got %h expected 0000", rdata); end
        checks++; if (sram_dout !== 16'h0) begin errors++; $display("FAIL store_dout_resp: got %h expected 0000", sram_dout); end
        step();
    endtask

    task automatic test_ctrlr_read();
        req = 1'b1; we = 1'b0; addr = 16'hFDF2; ctrlr_din = 16'h0081;
        step();
        req = 1'b0;
        checks++; if ({strb, ctrlr_addr} !== 5'b100_10) begin errors++; $display("FAIL ctrlr_strobe: got %b expected 10010", {strb, ctrlr_addr}); end
        checks++; if ({sram_ctl, ack} !== 4'b1110) begin errors++; $display("FAIL ctrlr_sram_ack: got %b expected 1110", {sram_ctl, ack}); end
        step();
        checks++; if ({ack, err, strb, ctrlr_addr} !== 7'b10_000_00) begin
            errors++; $display("FAIL ctrlr_resp: got %b expected 1000000", {ack, err, strb, ctrlr_addr}); end
        checks++; if (rdata !== 16'h0081) begin errors++; $display("FAIL ctrlr_rdata: got %h expected 0081", rdata); end
        step();
    endtask

    task automatic test_audio_timer_error();
        req = 1'b1; we = 1'b1; addr = 16'hFDF5; wdata = 16'h0300;
        step();
        req = 1'b0;
        checks++; if ({strb, audio_addr, audio_dout} !== {3'b010, 2'b01, 16'h0300}) begin
            errors++; $display("FAIL audio_strobe: got %b/%b/%h expected 010/01/0300", strb, audio_addr, audio_dout); end
        step();
        checks++; if ({ack, err, strb, audio_dout} !== {2'b10, 3'b000, 16'h0}) begin
            errors++; $display("FAIL audio_resp: got %b/%h expected 10000/0000", {ack, err, strb}, audio_dout); end
        step();
        req = 1'b1; we = 1'b0; addr = 16'hFDF8; timer_din = 16'h1357;
        step();
        req = 1'b0;
        checks++; if (strb !== 3'b001) begin errors++; $display("FAIL timer_strobe: got %b expected 001", strb); end
        step();
        checks++; if ({ack, err, rdata} !== {2'b10, 16'h1357}) begin errors++; $display("FAIL timer_resp: got %b/%h expected 10/1357", {ack, err}, rdata); end
        step();
        req = 1'b1; we = 1'b0; addr = 16'hFDFC;
        step();
        req = 1'b0;
        checks++; if (strb !== 3'b000) begin errors++; $display("FAIL err_load_strobe: got %b expected 000", strb); end
        step();
        checks++; if ({ack, err, rdata} !== {2'b11, 16'h0}) begin errors++; $display("FAIL err_load_resp: got %b/%h expected 11/0000", {ack, err}, rdata); end
        step();
        req = 1'b1; we = 1'b1; addr = 16'hFDF0; wdata = 16'hFFFF;
        step();
        req = 1'b0;
        checks++; if (strb !== 3'b000) begin errors++; $display("FAIL err_store_strobe: got %b expected 000", strb); end
        step();
        checks++; if ({ack, err} !== 2'b11) begin errors++; $display("FAIL err_store_resp: got %b expected 11", {ack, err}); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [9:0] ce_tr, ack_tr, busy_tr;
        logic [15:0] rd3, rd8;
        ce_tr = '0; ack_tr = '0; busy_tr = '0; rd3 = '0; rd8 = '0;
        req = 1'b1; we = 1'b0; addr = 16'h0100; sram_din = 16'h1111;
        step();
        for (int i = 0; i < 10; i++) begin
            ce_tr[i] = sram_ce_n; ack_tr[i] = ack; busy_tr[i] = busy;
            if (i == 3) begin rd3 = rdata; sram_din = 16'h2222; end
            if (i == 5) req = 1'b0;
            if (i == 8) rd8 = rdata;
            step();
        end
        checks++; if (ce_tr !== 10'h318) begin errors++; $display("FAIL b2b_ce_trace: got %h expected 318", ce_tr); end
        checks++; if (ack_tr !== 10'h108) begin errors++; $display("FAIL b2b_ack_trace: got %h expected 108", ack_tr); end
        checks++; if (busy_tr !== 10'h1EF) begin errors++; $display("FAIL b2b_busy_trace: got %h expected 1ef", busy_tr); end
        checks++; if ({rd3, rd8} !== {16'h1111, 16'h2222}) begin errors++; $display("FAIL b2b_rdata: got %h/%h expected 1111/2222", rd3, rd8); end
    endtask

    task automatic test_reset_mid();
        req = 1'b1; we = 1'b0; addr = 16'h0200; sram_din = 16'h5555;
        step();
        req = 1'b0;
        step();
        checks++; if (sram_ctl !== 3'b001) begin errors++; $display("FAIL mid_pre_ctl: got %b expected 001", sram_ctl); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({sram_ctl, busy, ack} !== 5'b111_00) begin errors++; $display("FAIL mid_async: got %b expected 11100", {sram_ctl, busy, ack}); end
        checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL mid_rdata: got %h expected 0000", rdata); end
        step();
        checks++; if ({ack, busy} !== 2'b00) begin errors++; $display("FAIL mid_held: got %b expected 00", {ack, busy}); end
        @(negedge clk);
        reset = 1'b0; req = 1'b1; addr = 16'h0300; sram_din = 16'hCAFE;
        step();
        req = 1'b0;
        checks++; if ({sram_ctl, busy, sram_addr} !== {3'b001, 1'b1, 16'h0300}) begin
            errors++; $display("FAIL mid_accept: got %b/%b/%h expected 001/1/0300", sram_ctl, busy, sram_addr); end
        step();
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mid_no_early_ack: got %b expected 0", ack); end
        step();
        step();
        checks++; if ({ack, err, rdata} !== {2'b10, 16'hCAFE}) begin errors++; $display("FAIL mid_new_resp: got %b/%h expected 10/cafe", {ack, err}, rdata); end
        step();
    endtask

    initial begin
        test_reset();
        test_sram_load();
        test_sram_store();
        test_ctrlr_read();
        test_audio_timer_error();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
